// File: rtl/i2c_regxfer_if.sv
// i2c_regxfer_if: command/status bus between the transaction
// sequencer (master side) and the bit-level I2C engine (slave side).
interface i2c_regxfer_if;
   logic        wrcmd;
   logic [63:0] command;
   logic [63:0] mstatus;

   modport master (output wrcmd, output command, input mstatus);
   modport slave  (input wrcmd, input command, output mstatus);
endinterface

// File: rtl/i2c_regxfer.sv
// i2c_regxfer: register-level request -> I2C master command sequencer.
// Build option I2C_RETRY_EN re-attempts failed transfers RETRIES times.
module i2c_regxfer #(
   parameter int RETRIES = 3
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   input  logic          req,
   input  logic          rnw,
   input  logic [6:0]    devaddr,
   input  logic [7:0]    regaddr,
   input  logic [1:0]    nbm1,
   input  logic [31:0]   wdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [31:0]   rdata,
   i2c_regxfer_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_BUILD, S_ISSUE, S_GAP, S_POLL,
      S_CLEAN, S_CGAP, S_CPOLL, S_FAIL, S_DONE
   } state_t;

   state_t      state;
   logic        l_rnw;
   logic [6:0]  l_dev;
   logic [7:0]  l_reg;
   logic [1:0]  l_nbm1;
   logic [31:0] l_wdata;

`ifdef I2C_RETRY_EN
   localparam int CW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
   logic [CW-1:0] retry_cnt;
`else
   if (RETRIES < 0) begin : g_retries_ignored
   end
`endif

   // ops are 2-bit fields from bit 63 down; zero tail doubles as the stop op
   function automatic logic [63:0] build_cmd(
      input logic        r,
      input logic [6:0]  dev,
      input logic [7:0]  ra,
      input logic [1:0]  nb,
      input logic [31:0] wd
   );
      logic [63:0] c;
      c = '0;
      c[63:44] = {2'b11, dev, 1'b0, 2'b11, ra};
      if (r) begin
         c[43:32] = {2'b01, 2'b11, dev, 1'b1};
         for (int k = 0; k < 4; k++)
            if (k <= int'(nb)) c[31-2*k -: 2] = 2'b10;
      end else begin
         for (int k = 0; k < 4; k++)
            if (k <= int'(nb)) c[43-10*k -: 10] = {2'b11, wd[8*k +: 8]};
      end
      return c;
   endfunction

   // first received byte sits highest in the shifted status field
   function automatic logic [31:0] read_bytes(
      input logic [31:0] sh,
      input logic [1:0]  nb
   );
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 4; k++)
         if (k <= int'(nb)) r[8*k +: 8] = sh[8*(int'(nb)-k) +: 8];
      return r;
   endfunction

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         rdata       <= '0;
         bus.wrcmd   <= 1'b0;
         bus.command <= '0;
         l_rnw       <= 1'b0;
         l_dev       <= '0;
         l_reg       <= '0;
         l_nbm1      <= '0;
         l_wdata     <= '0;
`ifdef I2C_RETRY_EN
         retry_cnt   <= '0;
`endif
      end else begin
         done      <= 1'b0;
         bus.wrcmd <= 1'b0;
         unique case (state)
            S_IDLE: if (req) begin
               l_rnw   <= rnw;
               l_dev   <= devaddr;
               l_reg   <= regaddr;
               l_nbm1  <= nbm1;
               l_wdata <= wdata;
               busy    <= 1'b1;
               err     <= 1'b0;
`ifdef I2C_RETRY_EN
               retry_cnt <= CW'(RETRIES);
`endif
               state   <= S_BUILD;
            end
            S_BUILD: begin
               bus.command <= build_cmd(l_rnw, l_dev, l_reg,
                                        l_nbm1, l_wdata);
               bus.wrcmd   <= 1'b1;
               state       <= S_ISSUE;
            end
            S_ISSUE: state <= S_GAP;
            S_GAP:   state <= S_POLL;
            S_POLL: if (!bus.mstatus[63]) begin
               if (bus.mstatus[62]) begin
                  bus.command <= '0;
                  bus.wrcmd   <= 1'b1;
                  state       <= S_CLEAN;
               end else begin
                  if (l_rnw)
                     rdata <= read_bytes(bus.mstatus[31:0], l_nbm1);
                  state <= S_DONE;
               end
            end
            S_CLEAN: state <= S_CGAP;
            S_CGAP:  state <= S_CPOLL;
            S_CPOLL: if (!bus.mstatus[63]) state <= S_FAIL;
            S_FAIL: begin
`ifdef I2C_RETRY_EN
               if (retry_cnt != '0) begin
                  retry_cnt <= retry_cnt - CW'(1);
                  state     <= S_BUILD;
               end else begin
                  err   <= 1'b1;
                  state <= S_DONE;
               end
`else
               err   <= 1'b1;
               state <= S_DONE;
`endif
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
